instruction_dispatcher: RTL and testbench

Processor-side initiator for the video processor's instruction port. Buffers (dataA, dataB) instruction pairs in a synchronous FIFO. Issues each pair as a one-cycle `clk_en` strobe, only while the screen is not being printed, and waits for the completion pulse before issuing the next. Sits between the CPU bus/custom-instruction logic and the `video_processor` inputs `clk_en`/`dataA`/`dataB`.

---
 rtl/instruction_dispatcher.sv | 155 +++++++++++++++
 tb/tb_instruction_dispatcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_dispatcher.sv
// Buffers (dataA, dataB) pairs in a FIFO and issues them one at a time to the video processor.
// Optional WAIT_DONE watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module instruction_dispatcher #(
  parameter int FIFO_DEPTH     = 16,
  parameter int PTR_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [31:0]    wr_dataA,
  input  logic [31:0]    wr_dataB,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count,
  input  logic           in_printtingScreen,
  input  logic           instruction_done,
  output logic           out_clk_en,
  output logic [31:0]    out_dataA,
  output logic [31:0]    out_dataB,
  output logic           busy,
  output logic           timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_WINDOW, ISSUE, WAIT_DONE} state_t;

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [63:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic             full_reg, empty_reg;
  state_t           state_reg;
  logic             out_clk_en_reg, busy_reg;
  logic [31:0]      out_dataA_reg, out_dataB_reg;
  logic             push, pop;

  // A pop is only ever taken while waiting to issue and the screen is idle.
  assign push = wr_en && !full_reg;
  assign pop  = ((state_reg == IDLE) || (state_reg == WAIT_WINDOW)) &&
                !empty_reg && !in_printtingScreen;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_ONE;
    else if (pop && !push)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr_reg] <= {wr_dataA, wr_dataB};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      empty_reg <= (count_next == '0);
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int            WAIT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      out_clk_en_reg <= 1'b0;
      busy_reg       <= 1'b0;
      out_dataA_reg  <= '0;
      out_dataB_reg  <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      out_clk_en_reg <= 1'b0;
      // The head word is read straight out of the array into the output registers.
      if (pop) begin
        {out_dataA_reg, out_dataB_reg} <= mem[rd_ptr_reg];
        out_clk_en_reg <= 1'b1;
        busy_reg       <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pop)
            state_reg <= ISSUE;
          else if (!empty_reg)
            state_reg <= WAIT_WINDOW;
        end
        WAIT_WINDOW: begin
          if (pop)
            state_reg <= ISSUE;
        end
        ISSUE: begin
          state_reg <= WAIT_DONE;
`ifdef DISPATCH_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        WAIT_DONE: begin
          if (instruction_done) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign full       = full_reg;
  assign empty      = empty_reg;
  assign count      = count_reg;
  assign out_clk_en = out_clk_en_reg;
  assign out_dataA  = out_dataA_reg;
  assign out_dataB  = out_dataB_reg;
  assign busy       = busy_reg;

`ifdef DISPATCH_TIMEOUT_EN
  assign timeout_err = timeout_err_reg;
`else
  // Always 0 without the watchdog; the comparison only keeps the parameter referenced.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Scoreboard bench for instruction_dispatcher: expected issue order queued at push, checked by a strobe monitor.
module tb_instruction_dispatcher;
  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset, wr_en;
  logic [31:0] wr_dataA, wr_dataB;
  logic        full, empty;
  logic [4:0]  count;
  logic        in_printtingScreen, instruction_done;
  logic        out_clk_en, busy, timeout_err;
  logic [31:0] out_dataA, out_dataB;
  logic        auto_pulse, manual_pulse;
  bit          auto_done;

  int          vectors = 0;
  int          miscompares = 0;
  int          accepted = 0;
  int          strobes = 0;
  int          ws = 0;            // 1 while the reference expects the DUT to wait for done
  logic [63:0] exp_q[$];
  logic [63:0] exp_word;
  logic        print_at_edge;
`ifdef DISPATCH_TIMEOUT_EN
  int          to_cnt = 0;
`endif

  assign instruction_done = auto_pulse | manual_pulse;

  instruction_dispatcher #(
    .FIFO_DEPTH(16), .PTR_W(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_dataA(wr_dataA), .wr_dataB(wr_dataB),
    .full(full), .empty(empty), .count(count),
    .in_printtingScreen(in_printtingScreen), .instruction_done(instruction_done),
    .out_clk_en(out_clk_en), .out_dataA(out_dataA), .out_dataB(out_dataB),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) print_at_edge <= in_printtingScreen;

  // Monitor: every strobe must carry the oldest expected pair and respect issue gating.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      ws = 0;
    end else if (out_clk_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: got %h, required no strobe", {out_dataA, out_dataB});
      end else begin
        exp_word = exp_q.pop_front();
        if ({out_dataA, out_dataB} !== exp_word) begin
          miscompares++;
          $display("FAIL strobe_data: got %h, required %h", {out_dataA, out_dataB}, exp_word);
        end
      end
      vectors++;
      if (print_at_edge !== 1'b0 || ws != 0) begin
        miscompares++;
        $display("FAIL strobe_gating: printing=%0b awaiting_done=%0d, required 0 and 0", print_at_edge, ws);
      end
      ws = 1;
      strobes++;
`ifdef DISPATCH_TIMEOUT_EN
      to_cnt = 0;
`endif
    end else if (ws == 1) begin
      if (instruction_done)
        ws = 0;
`ifdef DISPATCH_TIMEOUT_EN
      else begin
        to_cnt++;
        if (to_cnt == TB_TIMEOUT)
          ws = 0;
      end
`endif
    end
  end

  // Responder: pulses done 1..5 cycles into WAIT_DONE when enabled.
  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_done && out_clk_en && !reset) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 auto_pulse = 1'b1;
        @(posedge clk);
        #1 auto_pulse = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input bit accept);
    wr_en = 1'b1;
    wr_dataA = a;
    wr_dataB = b;
    if (accept) begin
      exp_q.push_back({a, b});
      accepted++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || ws != 0) && n < 3000) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL %s: drain timed out with %0d pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int s0;
    reset = 1'b1; wr_en = 1'b0; wr_dataA = '0; wr_dataB = '0;
    in_printtingScreen = 1'b0; manual_pulse = 1'b0; auto_done = 1'b0;
    repeat (3) tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobe", 64'(out_clk_en), 64'd0);
    check("rst_data", {out_dataA, out_dataB}, 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    tick();

    // Single instruction with the screen idle
    push(32'h50, 32'd694310912, 1'b1);
    check("t1_count_push", 64'(count), 64'd1);
    check("t1_no_early_strobe", 64'(out_clk_en), 64'd0);
    tick();
    check("t1_strobe", 64'(out_clk_en), 64'd1);
    check("t1_data", {out_dataA, out_dataB}, {32'h50, 32'd694310912});
    check("t1_count_pop", 64'(count), 64'd0);
    check("t1_busy_issue", 64'(busy), 64'd1);
    tick();
    check("t1_strobe_one_cycle", 64'(out_clk_en), 64'd0);
    repeat (3) tick();
    check("t1_busy_wait", 64'(busy), 64'd1);
    manual_pulse = 1'b1; tick(); manual_pulse = 1'b0;
    check("t1_busy_released", 64'(busy), 64'd0);
    check("t1_data_hold", {out_dataA, out_dataB}, {32'h50, 32'd694310912});

    // Blocked by printing, then FIFO-order release
    in_printtingScreen = 1'b1;
    for (int i = 0; i < 3; i++) push($urandom(), $urandom(), 1'b1);
    repeat (5) tick();
    check("t2_count_blocked", 64'(count), 64'd3);
    check("t2_busy_blocked", 64'(busy), 64'd0);
    auto_done = 1'b1;
    in_printtingScreen = 1'b0;
    drain("t2_drain");
    check("t2_empty", 64'(empty), 64'd1);

    // Overflow: 17th push dropped
    in_printtingScreen = 1'b1;
    for (int i = 0; i < 16; i++) push($urandom(), $urandom(), 1'b1);
    push(32'hDEAD_BEEF, 32'hBAD0_0017, 1'b0);
    check("t3_full", 64'(full), 64'd1);
    check("t3_count", 64'(count), 64'd16);
    s0 = strobes;
    in_printtingScreen = 1'b0;
    drain("t3_drain");
    check("t3_strobe_total", 64'(strobes - s0), 64'd16);
    check("t3_empty", 64'(empty), 64'd1);

    // Simultaneous push and pop
    auto_done = 1'b0;
    push(32'hA, 32'hA0, 1'b1);
    tick(); tick();
    push(32'hB, 32'hB0, 1'b1);
    manual_pulse = 1'b1; tick(); manual_pulse = 1'b0;
    push(32'hC, 32'hC0, 1'b1);
    check("t4_count_same", 64'(count), 64'd1);
    auto_done = 1'b1;
    drain("t4_drain");

    // Stray done pulses in IDLE and ISSUE
    auto_done = 1'b0;
    manual_pulse = 1'b1; tick(); manual_pulse = 1'b0;
    check("t5_idle_done", 64'(busy), 64'd0);
    push(32'h55, 32'h66, 1'b1);
    manual_pulse = 1'b1; tick(); tick(); manual_pulse = 1'b0;
    repeat (4) tick();
    check("t5_still_waiting", 64'(busy), 64'd1);
    manual_pulse = 1'b1; tick(); manual_pulse = 1'b0;
    check("t5_released", 64'(busy), 64'd0);

    // Randomized traffic with random printing windows
    auto_done = 1'b1;
    for (int i = 0; i < 80; i++) begin
      in_printtingScreen = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1 && (accepted - strobes) < 12)
        push($urandom(), $urandom(), 1'b1);
      else
        tick();
    end
    in_printtingScreen = 1'b0;
    drain("rand_drain");
    check("rand_empty", 64'(empty), 64'd1);

    // Reset in WAIT_DONE with 4 entries queued
    auto_done = 1'b0;
    push(32'h77, 32'h88, 1'b1);
    for (int i = 0; i < 4; i++) push($urandom(), $urandom(), 1'b1);
    tick();
    check("t6_count_queued", 64'(count), 64'd4);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_empty", 64'(empty), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_data", {out_dataA, out_dataB}, 64'd0);
    repeat (5) tick();
    check("t6_quiet", 64'(busy), 64'd0);

`ifdef DISPATCH_TIMEOUT_EN
    push(32'h1111, 32'h2222, 1'b1);
    push(32'h3333, 32'h4444, 1'b1);
    repeat (TB_TIMEOUT + 10) tick();
    check("to_flag", 64'(timeout_err), 64'd1);
    check("to_next_issued", 64'(exp_q.size()), 64'd0);
    repeat (TB_TIMEOUT + 4) tick();
    check("to_sticky", 64'(timeout_err), 64'd1);
`else
    check("to_disabled", 64'(timeout_err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
